ghr_spec_repair: RTL and testbench

//  Speculative global-history unit feeding the gshare PHT read index. Shifts predicted

---
 rtl/ghr_spec_repair_if.sv | 36 +++
 rtl/ghr_spec_repair.sv | 126 ++++++++++++
 tb/tb_ghr_spec_repair.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ghr_spec_repair_if.sv
// Pipeline-side connection of the speculative global-history unit: stage
// stalls/flushes, F prediction, E resolution and the history outputs.
interface ghr_spec_repair_if #(
   parameter int k = 10
);
   logic         StallF;
   logic         StallD;
   logic         StallE;
   logic         StallM;
   logic         StallW;
   logic         FlushD;
   logic         FlushE;
   logic         FlushM;
   logic         PredBranchF;
   logic         BPDirTakenF;
   logic         BranchE;
   logic         PCSrcE;
   logic [k-1:0] GHRNextF;
   logic [k-1:0] GHRM;
   logic [k-1:0] GHRCommit;
   logic         RepairE;

   modport master (
      output StallF, StallD, StallE, StallM, StallW,
      output FlushD, FlushE, FlushM,
      output PredBranchF, BPDirTakenF, BranchE, PCSrcE,
      input  GHRNextF, GHRM, GHRCommit, RepairE
   );

   modport slave (
      input  StallF, StallD, StallE, StallM, StallW,
      input  FlushD, FlushE, FlushM,
      input  PredBranchF, BPDirTakenF, BranchE, PCSrcE,
      output GHRNextF, GHRM, GHRCommit, RepairE
   );
endinterface

// File: rtl/ghr_spec_repair.sv
// Speculative global history for the gshare read index, with per-stage
// checkpoints, E-stage repair and a committed copy for trap recovery.
module ghr_spec_repair #(
   parameter int k = 10
) (
   input  logic               clk,
   input  logic               reset_n,
   ghr_spec_repair_if.slave   bus
);

   typedef struct packed {
      logic [k-1:0] hist;
      logic         shifted;
      logic         pred_dir;
   } ckpt_t;

   logic [k-1:0] r_ghr_spec;
   logic [k-1:0] r_ghr_commit;
   logic [k-1:0] w_ghr_next;
   logic [k-1:0] w_repair_val;
   ckpt_t        w_ckpt_f;
   ckpt_t        r_ckpt_d;
   ckpt_t        r_ckpt_e;
   ckpt_t        r_ckpt_m;
   logic         r_branch_m;
   logic         r_pcsrc_m;
   logic         w_shift_f;
   logic         w_mispred_e;
   logic         w_commit_m;
   logic         w_unused;

   assign w_unused = &{1'b0, bus.StallW};

   assign w_shift_f         = bus.PredBranchF & ~bus.StallF;
   assign w_ckpt_f.hist     = r_ghr_spec;
   assign w_ckpt_f.shifted  = w_shift_f;
   assign w_ckpt_f.pred_dir = bus.BPDirTakenF;
   assign w_commit_m        = ~bus.StallM & ~bus.FlushM & r_branch_m;

   // E-stage miscompare detection and repair value (false branches are un-shifted)
   always_comb begin
      w_mispred_e  = 1'b0;
      w_repair_val = r_ckpt_e.hist;
      if (!bus.StallE) begin
         if (bus.BranchE) begin
            w_mispred_e = ~r_ckpt_e.shifted | (bus.PCSrcE != r_ckpt_e.pred_dir);
         end else begin
            w_mispred_e = r_ckpt_e.shifted;
         end
      end else begin
         w_mispred_e = 1'b0;
      end
      if (bus.BranchE) begin
         w_repair_val = {bus.PCSrcE, r_ckpt_e.hist[k-1:1]};
      end else begin
         w_repair_val = r_ckpt_e.hist;
      end
   end

   // Next speculative history: trap recovery, then repair, then F shift, else hold
   always_comb begin
      w_ghr_next = r_ghr_spec;
      if (!reset_n) begin
         w_ghr_next = '0;
      end else if (bus.FlushM) begin
         w_ghr_next = r_ghr_commit;
      end else if (w_mispred_e) begin
         w_ghr_next = w_repair_val;
      end else if (w_shift_f) begin
         w_ghr_next = {bus.BPDirTakenF, r_ghr_spec[k-1:1]};
      end else begin
         w_ghr_next = r_ghr_spec;
      end
   end

   // Speculative and committed history registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ghr_spec   <= '0;
         r_ghr_commit <= '0;
      end else begin
         r_ghr_spec <= w_ghr_next;
         if (w_commit_m) begin
            r_ghr_commit <= {r_pcsrc_m, r_ghr_commit[k-1:1]};
         end
      end
   end

   // Checkpoint pipeline D/E/M; a flush clears the stage even when it is stalled
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ckpt_d   <= '0;
         r_ckpt_e   <= '0;
         r_ckpt_m   <= '0;
         r_branch_m <= 1'b0;
         r_pcsrc_m  <= 1'b0;
      end else begin
         if (bus.FlushD) begin
            r_ckpt_d <= '0;
         end else if (!bus.StallD) begin
            r_ckpt_d <= w_ckpt_f;
         end
         if (bus.FlushE) begin
            r_ckpt_e <= '0;
         end else if (!bus.StallE) begin
            r_ckpt_e <= r_ckpt_d;
         end
         if (bus.FlushM) begin
            r_ckpt_m   <= '0;
            r_branch_m <= 1'b0;
            r_pcsrc_m  <= 1'b0;
         end else if (!bus.StallM) begin
            r_ckpt_m   <= r_ckpt_e;
            r_branch_m <= bus.BranchE;
            r_pcsrc_m  <= bus.PCSrcE;
         end
      end
   end

   // Read index uses the same-cycle next history; reset forces quiet outputs
   assign bus.GHRNextF  = w_ghr_next;
   assign bus.RepairE   = w_mispred_e & reset_n;
   assign bus.GHRM      = r_ckpt_m.hist;
   assign bus.GHRCommit = r_ghr_commit;

endmodule

// File: tb/tb_ghr_spec_repair.sv
// Directed bench for ghr_spec_repair with k=4 and hand-computed histories.
module tb_ghr_spec_repair;

   logic clk;
   logic reset_n;
   int   total;
   int   bad;

   ghr_spec_repair_if #(.k(4)) bus ();

   ghr_spec_repair #(.k(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Idle: no prediction, no resolution, D flushed so nothing reaches E
   task automatic clr_in;
      bus.StallF = 1'b0; bus.StallD = 1'b0; bus.StallE = 1'b0;
      bus.StallM = 1'b0; bus.StallW = 1'b0;
      bus.FlushD = 1'b1; bus.FlushE = 1'b0; bus.FlushM = 1'b0;
      bus.PredBranchF = 1'b0; bus.BPDirTakenF = 1'b0;
      bus.BranchE = 1'b0; bus.PCSrcE = 1'b0;
   endtask

   task automatic shift_f(input logic dir);
      clr_in;
      bus.PredBranchF = 1'b1;
      bus.BPDirTakenF = dir;
      tick;
   endtask

   task automatic do_reset;
      clr_in;
      reset_n = 1'b0;
      tick;
      tick;
      reset_n = 1'b1;
   endtask

   task automatic test_reset;
      clr_in;
      bus.PredBranchF = 1'b1; bus.BPDirTakenF = 1'b1;
      reset_n = 1'b0;
      #2;
      total++; if (bus.GHRNextF !== 4'b0000) begin bad++; $display("FAIL rst_nextf: got %b want %b", bus.GHRNextF, 4'b0000); end
      total++; if (bus.GHRM !== 4'b0000) begin bad++; $display("FAIL rst_ghrm: got %b want %b", bus.GHRM, 4'b0000); end
      total++; if (bus.GHRCommit !== 4'b0000) begin bad++; $display("FAIL rst_commit: got %b want %b", bus.GHRCommit, 4'b0000); end
      total++; if (bus.RepairE !== 1'b0) begin bad++; $display("FAIL rst_repair: got %b want %b", bus.RepairE, 1'b0); end
      tick;
      reset_n = 1'b1;
      clr_in;
      #2;
      total++; if (bus.GHRNextF !== 4'b0000) begin bad++; $display("FAIL rst_idle: got %b want %b", bus.GHRNextF, 4'b0000); end
      tick;
   endtask

   task automatic test_back_to_back;
      logic       dirs [3];
      logic [3:0] exps [3];
      dirs = '{1'b1, 1'b0, 1'b1};
      exps = '{4'b1000, 4'b0100, 4'b1010};
      do_reset;
      for (int i = 0; i < 3; i++) begin
         clr_in;
         #2;
         total++; if (bus.GHRNextF !== ((i == 0) ? 4'b0000 : exps[i-1])) begin bad++; $display("FAIL b2b_spec%0d: got %b want %b", i, bus.GHRNextF, (i == 0) ? 4'b0000 : exps[i-1]); end
         bus.PredBranchF = 1'b1;
         bus.BPDirTakenF = dirs[i];
         #1;
         total++; if (bus.GHRNextF !== exps[i]) begin bad++; $display("FAIL b2b_next%0d: got %b want %b", i, bus.GHRNextF, exps[i]); end
         tick;
      end
      clr_in;
      #2;
      total++; if (bus.GHRNextF !== 4'b1010) begin bad++; $display("FAIL b2b_final: got %b want %b", bus.GHRNextF, 4'b1010); end
      tick;
   endtask

   task automatic test_async_reset;
      do_reset;
      shift_f(1'b1); shift_f(1'b1); shift_f(1'b0); shift_f(1'b1);
      clr_in;
      #2;
      total++; if (bus.GHRNextF !== 4'b1011) begin bad++; $display("FAIL arst_pre: got %b want %b", bus.GHRNextF, 4'b1011); end
      bus.PredBranchF = 1'b1; bus.BPDirTakenF = 1'b1;
      reset_n = 1'b0;
      #1;
      total++; if (bus.GHRNextF !== 4'b0000) begin bad++; $display("FAIL arst_nextf: got %b want %b", bus.GHRNextF, 4'b0000); end
      total++; if (bus.RepairE !== 1'b0) begin bad++; $display("FAIL arst_repair: got %b want %b", bus.RepairE, 1'b0); end
      tick;
      reset_n = 1'b1;
      clr_in;
      #2;
      total++; if (bus.GHRNextF !== 4'b0000) begin bad++; $display("FAIL arst_resume: got %b want %b", bus.GHRNextF, 4'b0000); end
      bus.PredBranchF = 1'b1; bus.BPDirTakenF = 1'b1;
      #1;
      total++; if (bus.GHRNextF !== 4'b1000) begin bad++; $display("FAIL arst_fresh: got %b want %b", bus.GHRNextF, 4'b1000); end
      tick;
   endtask

   task automatic test_repair_branch;
      do_reset;
      shift_f(1'b1); shift_f(1'b0);
      clr_in; bus.PredBranchF = 1'b1; bus.BPDirTakenF = 1'b1; bus.FlushD = 1'b0;
      tick;
      clr_in;
      tick;
      clr_in; bus.PredBranchF = 1'b1; bus.BPDirTakenF = 1'b1;
      bus.BranchE = 1'b1; bus.PCSrcE = 1'b0;
      #2;
      total++; if (bus.RepairE !== 1'b1) begin bad++; $display("FAIL rep_br_flag: got %b want %b", bus.RepairE, 1'b1); end
      total++; if (bus.GHRNextF !== 4'b0010) begin bad++; $display("FAIL rep_br_next: got %b want %b", bus.GHRNextF, 4'b0010); end
      tick;
      clr_in;
      #2;
      total++; if (bus.RepairE !== 1'b0) begin bad++; $display("FAIL rep_br_clear: got %b want %b", bus.RepairE, 1'b0); end
      total++; if (bus.GHRNextF !== 4'b0010) begin bad++; $display("FAIL rep_br_spec: got %b want %b", bus.GHRNextF, 4'b0010); end
      total++; if (bus.GHRM !== 4'b0100) begin bad++; $display("FAIL rep_br_ghrm: got %b want %b", bus.GHRM, 4'b0100); end
      tick;
   endtask

   task automatic test_repair_nonbranch;
      do_reset;
      shift_f(1'b1); shift_f(1'b1); shift_f(1'b0);
      clr_in; bus.PredBranchF = 1'b1; bus.BPDirTakenF = 1'b1; bus.FlushD = 1'b0;
      tick;
      clr_in;
      tick;
      clr_in;
      #2;
      total++; if (bus.RepairE !== 1'b1) begin bad++; $display("FAIL rep_nb_flag: got %b want %b", bus.RepairE, 1'b1); end
      total++; if (bus.GHRNextF !== 4'b0110) begin bad++; $display("FAIL rep_nb_next: got %b want %b", bus.GHRNextF, 4'b0110); end
      tick;
      clr_in; bus.FlushD = 1'b0;
      #2;
      total++; if (bus.GHRNextF !== 4'b0110) begin bad++; $display("FAIL rep_nb_spec: got %b want %b", bus.GHRNextF, 4'b0110); end
      tick;
      clr_in;
      tick;
      clr_in; bus.BranchE = 1'b1; bus.PCSrcE = 1'b1;
      #2;
      total++; if (bus.RepairE !== 1'b1) begin bad++; $display("FAIL btbmiss_flag: got %b want %b", bus.RepairE, 1'b1); end
      total++; if (bus.GHRNextF !== 4'b1011) begin bad++; $display("FAIL btbmiss_next: got %b want %b", bus.GHRNextF, 4'b1011); end
      tick;
      clr_in; bus.PredBranchF = 1'b1; bus.BPDirTakenF = 1'b0; bus.FlushD = 1'b0;
      #2;
      total++; if (bus.GHRNextF !== 4'b0101) begin bad++; $display("FAIL okpred_shift: got %b want %b", bus.GHRNextF, 4'b0101); end
      tick;
      clr_in;
      tick;
      clr_in; bus.BranchE = 1'b1; bus.PCSrcE = 1'b0;
      #2;
      total++; if (bus.RepairE !== 1'b0) begin bad++; $display("FAIL okpred_flag: got %b want %b", bus.RepairE, 1'b0); end
      total++; if (bus.GHRNextF !== 4'b0101) begin bad++; $display("FAIL okpred_hold: got %b want %b", bus.GHRNextF, 4'b0101); end
      tick;
   endtask

   task automatic test_stall_f;
      do_reset;
      for (int i = 0; i < 3; i++) begin
         clr_in; bus.StallF = 1'b1; bus.PredBranchF = 1'b1; bus.BPDirTakenF = 1'b1;
         #2;
         total++; if (bus.GHRNextF !== 4'b0000) begin bad++; $display("FAIL stallf_%0d: got %b want %b", i, bus.GHRNextF, 4'b0000); end
         tick;
      end
      clr_in; bus.PredBranchF = 1'b1; bus.BPDirTakenF = 1'b1;
      #2;
      total++; if (bus.GHRNextF !== 4'b1000) begin bad++; $display("FAIL stallf_rel: got %b want %b", bus.GHRNextF, 4'b1000); end
      tick;
      clr_in;
      #2;
      total++; if (bus.GHRNextF !== 4'b1000) begin bad++; $display("FAIL stallf_once: got %b want %b", bus.GHRNextF, 4'b1000); end
      tick;
   endtask

   task automatic test_stall_repair;
      do_reset;
      clr_in; bus.PredBranchF = 1'b1; bus.BPDirTakenF = 1'b1; bus.FlushD = 1'b0;
      tick;
      clr_in;
      tick;
      for (int i = 0; i < 2; i++) begin
         clr_in; bus.StallE = 1'b1; bus.StallD = 1'b1;
         bus.BranchE = 1'b1; bus.PCSrcE = 1'b0;
         #2;
         total++; if (bus.RepairE !== 1'b0) begin bad++; $display("FAIL stalle_flag%0d: got %b want %b", i, bus.RepairE, 1'b0); end
         total++; if (bus.GHRNextF !== 4'b1000) begin bad++; $display("FAIL stalle_hold%0d: got %b want %b", i, bus.GHRNextF, 4'b1000); end
         tick;
      end
      clr_in; bus.FlushE = 1'b1; bus.BranchE = 1'b1; bus.PCSrcE = 1'b0;
      #2;
      total++; if (bus.RepairE !== 1'b1) begin bad++; $display("FAIL stalle_rel_flag: got %b want %b", bus.RepairE, 1'b1); end
      total++; if (bus.GHRNextF !== 4'b0000) begin bad++; $display("FAIL stalle_rel_next: got %b want %b", bus.GHRNextF, 4'b0000); end
      tick;
      clr_in;
      #2;
      total++; if (bus.GHRNextF !== 4'b0000) begin bad++; $display("FAIL stalle_after: got %b want %b", bus.GHRNextF, 4'b0000); end
      tick;
   endtask

   task automatic test_flushm_commit;
      logic pcs [4];
      pcs = '{1'b1, 1'b1, 1'b0, 1'b0};
      do_reset;
      for (int i = 0; i < 4; i++) begin
         clr_in; bus.BranchE = 1'b1; bus.PCSrcE = pcs[i];
         tick;
      end
      shift_f(1'b1); shift_f(1'b0); shift_f(1'b1); shift_f(1'b1);
      clr_in;
      #2;
      total++; if (bus.GHRNextF !== 4'b1101) begin bad++; $display("FAIL fm_spec: got %b want %b", bus.GHRNextF, 4'b1101); end
      total++; if (bus.GHRCommit !== 4'b0011) begin bad++; $display("FAIL fm_commit: got %b want %b", bus.GHRCommit, 4'b0011); end
      tick;
      clr_in; bus.FlushM = 1'b1;
      #2;
      total++; if (bus.GHRNextF !== 4'b0011) begin bad++; $display("FAIL fm_next: got %b want %b", bus.GHRNextF, 4'b0011); end
      tick;
      clr_in;
      #2;
      total++; if (bus.GHRNextF !== 4'b0011) begin bad++; $display("FAIL fm_restored: got %b want %b", bus.GHRNextF, 4'b0011); end
      tick;
      clr_in; bus.PredBranchF = 1'b1; bus.BPDirTakenF = 1'b1; bus.FlushD = 1'b0;
      tick;
      clr_in;
      tick;
      clr_in; bus.BranchE = 1'b1; bus.PCSrcE = 1'b1;
      #2;
      total++; if (bus.RepairE !== 1'b0) begin bad++; $display("FAIL cm_norepair: got %b want %b", bus.RepairE, 1'b0); end
      tick;
      clr_in;
      #2;
      total++; if (bus.GHRM !== 4'b0011) begin bad++; $display("FAIL cm_ghrm: got %b want %b", bus.GHRM, 4'b0011); end
      total++; if (bus.GHRCommit !== 4'b0011) begin bad++; $display("FAIL cm_pre: got %b want %b", bus.GHRCommit, 4'b0011); end
      tick;
      clr_in;
      #2;
      total++; if (bus.GHRCommit !== 4'b1001) begin bad++; $display("FAIL cm_post: got %b want %b", bus.GHRCommit, 4'b1001); end
      total++; if (bus.GHRNextF !== 4'b1001) begin bad++; $display("FAIL cm_spec: got %b want %b", bus.GHRNextF, 4'b1001); end
      tick;
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      reset_n = 1'b0;
      clr_in;
      test_reset;
      test_back_to_back;
      test_async_reset;
      test_repair_branch;
      test_repair_nonbranch;
      test_stall_f;
      test_stall_repair;
      test_flushm_commit;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
